// File: rtl/usb_pkg.sv
// Shared definitions for the USB full-speed device transaction sequencer:
// PID encodings, sequencer states and a small PID classification helper.
package usb_pkg;

    localparam logic [3:0] PID_OUT   = 4'b0001;
    localparam logic [3:0] PID_IN    = 4'b1001;
    localparam logic [3:0] PID_SOF   = 4'b0101;
    localparam logic [3:0] PID_SETUP = 4'b1101;
    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_ACK   = 4'b0010;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_DATA,
        ST_SEND_HS,
        ST_SEND_DATA,
        ST_WAIT_ACK
    } state_t;

    function automatic logic is_data_pid(input logic [3:0] pid);
        return (pid == PID_DATA0) || (pid == PID_DATA1);
    endfunction

endpackage

// File: rtl/usb_ep_toggle.sv
// Per-endpoint DATA0/DATA1 toggle bank: one OUT and one IN toggle per endpoint,
// all accesses on the endpoint selected by 'ep'.
module usb_ep_toggle #(
    parameter int NUM_EP = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] ep,
    input  logic       out_flip,
    input  logic       in_flip,
    input  logic       setup_set,
    output logic       out_tog,
    output logic       in_tog
);

    logic [NUM_EP-1:0] out_q;
    logic [NUM_EP-1:0] in_q;

    // A completed SETUP forces both directions to DATA1, overriding any flip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
            in_q  <= '0;
        end else begin
            for (int i = 0; i < NUM_EP; i++) begin
                if (ep == 4'(i)) begin
                    if (setup_set) begin
                        out_q[i] <= 1'b1;
                        in_q[i]  <= 1'b1;
                    end else begin
                        if (out_flip) out_q[i] <= ~out_q[i];
                        if (in_flip)  in_q[i]  <= ~in_q[i];
                    end
                end
            end
        end
    end

    always_comb begin
        out_tog = 1'b0;
        in_tog  = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep == 4'(i)) begin
                out_tog = out_q[i];
                in_tog  = in_q[i];
            end
        end
    end

endmodule

// File: rtl/usb_transaction_ctrl.sv
// Device-side USB full-speed transaction sequencer: decodes tokens, routes OUT/SETUP
// payloads, issues handshakes or IN data, tracks toggles and times out the host.
module usb_transaction_ctrl
    import usb_pkg::*;
#(
    parameter int NUM_EP      = 4,
    parameter int TIMEOUT_CYC = 400
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [6:0]        dev_addr,
    input  logic [NUM_EP-1:0] ep_stall,
    input  logic [3:0]        rx_packet_pid,
    input  logic [10:0]       rx_packet_addr,
    input  logic [7:0]        rx_packet_byte,
    input  logic              rx_packet_byte_en,
    input  logic              rx_packet_valid,
    input  logic              rx_packet_fin,
    output logic              tx_start,
    output logic [3:0]        tx_pid,
    input  logic              tx_done,
    output logic [3:0]        cur_ep,
    output logic [7:0]        out_byte,
    output logic              out_byte_en,
    output logic              out_setup,
    input  logic              out_ready,
    output logic              out_commit,
    output logic              out_abort,
    input  logic              in_ready,
    output logic              in_acked,
    output logic              sof_pulse,
    output logic [10:0]       frame_num
);

    localparam int             CW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYC - 1);

    state_t        state, state_nxt;
    logic [CW-1:0] to_cnt;
    logic          rx_busy;

    logic [3:0]  tok_ep;
    logic        addr_hit;
    logic [3:0]  ep_sel;
    logic        stall_sel;
    logic        out_tog, in_tog;
    logic        fin_ok, waiting, frozen, timeout, exp_tog;

    logic        tx_start_nxt, commit_nxt, abort_nxt, acked_nxt, sof_nxt, setup_nxt;
    logic [3:0]  tx_pid_nxt, cur_ep_nxt;
    logic [10:0] frame_nxt;
    logic        out_flip, in_flip, setup_set;

    assign tok_ep   = rx_packet_addr[10:7];
    assign addr_hit = (rx_packet_addr[6:0] == dev_addr) && ({1'b0, tok_ep} < 5'(NUM_EP));
    assign ep_sel   = (state == ST_IDLE) ? tok_ep : cur_ep;
    assign fin_ok   = rx_packet_fin && rx_packet_valid;
    assign waiting  = (state == ST_WAIT_DATA) || (state == ST_WAIT_ACK);
    assign frozen   = rx_busy || rx_packet_byte_en;
    assign timeout  = waiting && !frozen && !rx_packet_fin && (to_cnt == TO_LAST);
    assign exp_tog  = out_setup ? 1'b0 : out_tog;

    always_comb begin
        stall_sel = 1'b0;
        for (int i = 0; i < NUM_EP; i++) begin
            if (ep_sel == 4'(i)) stall_sel = ep_stall[i];
        end
    end

    usb_ep_toggle #(.NUM_EP(NUM_EP)) u_toggle (
        .clk       (clk),
        .rst_n     (rst_n),
        .ep        (ep_sel),
        .out_flip  (out_flip),
        .in_flip   (in_flip),
        .setup_set (setup_set),
        .out_tog   (out_tog),
        .in_tog    (in_tog)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt    = state;
        tx_start_nxt = 1'b0;
        tx_pid_nxt   = tx_pid;
        commit_nxt   = 1'b0;
        abort_nxt    = 1'b0;
        acked_nxt    = 1'b0;
        sof_nxt      = 1'b0;
        frame_nxt    = frame_num;
        cur_ep_nxt   = cur_ep;
        setup_nxt    = out_setup;
        out_flip     = 1'b0;
        in_flip      = 1'b0;
        setup_set    = 1'b0;

        case (state)
            ST_IDLE: begin
                if (fin_ok) begin
                    if (rx_packet_pid == PID_SOF) begin
                        sof_nxt   = 1'b1;
                        frame_nxt = rx_packet_addr;
                    end else if (addr_hit) begin
                        case (rx_packet_pid)
                            PID_OUT, PID_SETUP: begin
                                cur_ep_nxt = tok_ep;
                                setup_nxt  = (rx_packet_pid == PID_SETUP);
                                state_nxt  = ST_WAIT_DATA;
                            end
                            PID_IN: begin
                                cur_ep_nxt   = tok_ep;
                                setup_nxt    = 1'b0;
                                tx_start_nxt = 1'b1;
                                if (stall_sel) begin
                                    tx_pid_nxt = PID_STALL;
                                    state_nxt  = ST_SEND_HS;
                                end else if (!in_ready) begin
                                    tx_pid_nxt = PID_NAK;
                                    state_nxt  = ST_SEND_HS;
                                end else begin
                                    tx_pid_nxt = in_tog ? PID_DATA1 : PID_DATA0;
                                    state_nxt  = ST_SEND_DATA;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end

            // A SETUP payload ignores the halt and always expects DATA0.
            ST_WAIT_DATA: begin
                if (rx_packet_fin) begin
                    state_nxt = ST_IDLE;
                    if (rx_packet_valid && is_data_pid(rx_packet_pid)) begin
                        tx_start_nxt = 1'b1;
                        state_nxt    = ST_SEND_HS;
                        if (stall_sel && !out_setup) begin
                            tx_pid_nxt = PID_STALL;
                            abort_nxt  = 1'b1;
                        end else if (!out_ready) begin
                            tx_pid_nxt = PID_NAK;
                            abort_nxt  = 1'b1;
                        end else if ((rx_packet_pid == PID_DATA1) != exp_tog) begin
                            tx_pid_nxt = PID_ACK;
                            abort_nxt  = 1'b1;
                        end else begin
                            tx_pid_nxt = PID_ACK;
                            commit_nxt = 1'b1;
                            setup_set  = out_setup;
                            out_flip   = !out_setup;
                        end
                    end else begin
                        abort_nxt = 1'b1;
                    end
                end else if (timeout) begin
                    abort_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end

            ST_SEND_HS: begin
                if (tx_done) state_nxt = ST_IDLE;
            end

            ST_SEND_DATA: begin
                if (tx_done) state_nxt = ST_WAIT_ACK;
            end

            // Without a valid ACK the toggle stays put so the retry resends the same data.
            ST_WAIT_ACK: begin
                if (rx_packet_fin) begin
                    state_nxt = ST_IDLE;
                    if (fin_ok && (rx_packet_pid == PID_ACK)) begin
                        acked_nxt = 1'b1;
                        in_flip   = 1'b1;
                    end
                end else if (timeout) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_start   <= 1'b0;
            tx_pid     <= 4'h0;
            out_commit <= 1'b0;
            out_abort  <= 1'b0;
            in_acked   <= 1'b0;
            sof_pulse  <= 1'b0;
            frame_num  <= 11'h000;
            cur_ep     <= 4'h0;
            out_setup  <= 1'b0;
        end else begin
            tx_start   <= tx_start_nxt;
            tx_pid     <= tx_pid_nxt;
            out_commit <= commit_nxt;
            out_abort  <= abort_nxt;
            in_acked   <= acked_nxt;
            sof_pulse  <= sof_nxt;
            frame_num  <= frame_nxt;
            cur_ep     <= cur_ep_nxt;
            out_setup  <= setup_nxt;
        end
    end

    // The timeout counter is held at zero outside the wait states and paused mid-packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            to_cnt      <= '0;
            rx_busy     <= 1'b0;
            out_byte    <= 8'h00;
            out_byte_en <= 1'b0;
        end else begin
            if (!waiting)                          to_cnt <= '0;
            else if (!frozen && to_cnt != TO_LAST) to_cnt <= to_cnt + 1'b1;

            if (rx_packet_fin)          rx_busy <= 1'b0;
            else if (rx_packet_byte_en) rx_busy <= 1'b1;

            out_byte_en <= (state == ST_WAIT_DATA) && rx_packet_byte_en;
            if ((state == ST_WAIT_DATA) && rx_packet_byte_en) out_byte <= rx_packet_byte;
        end
    end

endmodule

// File: tb/tb_usb_transaction_ctrl.sv
// Randomized self-checking bench for usb_transaction_ctrl against a transaction-level
// model of the endpoint toggles, handshake rules and payload forwarding.
module tb_usb_transaction_ctrl;
    import usb_pkg::*;

    localparam int         NUM_EP      = 4;
    localparam int         TIMEOUT_CYC = 400;
    localparam logic [6:0] MY_ADDR     = 7'h07;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [6:0]        dev_addr;
    logic [NUM_EP-1:0] ep_stall;
    logic [3:0]        rx_packet_pid;
    logic [10:0]       rx_packet_addr;
    logic [7:0]        rx_packet_byte;
    logic              rx_packet_byte_en, rx_packet_valid, rx_packet_fin;
    logic              tx_start, tx_done;
    logic [3:0]        tx_pid, cur_ep;
    logic [7:0]        out_byte;
    logic              out_byte_en, out_setup, out_ready, out_commit, out_abort;
    logic              in_ready, in_acked, sof_pulse;
    logic [10:0]       frame_num;

    usb_transaction_ctrl #(.NUM_EP(NUM_EP), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
        .clk(clk), .rst_n(rst_n), .dev_addr(dev_addr), .ep_stall(ep_stall),
        .rx_packet_pid(rx_packet_pid), .rx_packet_addr(rx_packet_addr),
        .rx_packet_byte(rx_packet_byte), .rx_packet_byte_en(rx_packet_byte_en),
        .rx_packet_valid(rx_packet_valid), .rx_packet_fin(rx_packet_fin),
        .tx_start(tx_start), .tx_pid(tx_pid), .tx_done(tx_done), .cur_ep(cur_ep),
        .out_byte(out_byte), .out_byte_en(out_byte_en), .out_setup(out_setup),
        .out_ready(out_ready), .out_commit(out_commit), .out_abort(out_abort),
        .in_ready(in_ready), .in_acked(in_acked), .sof_pulse(sof_pulse),
        .frame_num(frame_num)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    bit          m_out_tog [NUM_EP];
    bit          m_in_tog  [NUM_EP];
    logic [10:0] m_frame;
    logic [7:0]  payload [16];

    int          got_cnt, got_sum;
    logic        obs_start, obs_commit, obs_abort, obs_acked, obs_sof;
    logic [3:0]  obs_pid;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic sampleBytes();
        if (out_byte_en) begin
            got_cnt++;
            got_sum += int'(out_byte);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] pid, input logic [10:0] addr,
                                 input int nbytes, input logic valid);
        got_cnt = 0;
        got_sum = 0;
        for (int i = 0; i < nbytes; i++) begin
            @(negedge clk); sampleBytes();
            rx_packet_byte    = payload[i];
            rx_packet_byte_en = 1'b1;
        end
        @(negedge clk); sampleBytes();
        rx_packet_byte_en = 1'b0;
        rx_packet_pid     = pid;
        rx_packet_addr    = addr;
        rx_packet_valid   = valid;
        rx_packet_fin     = 1'b1;
        @(negedge clk); sampleBytes();
        rx_packet_fin   = 1'b0;
        rx_packet_valid = 1'b0;
        obs_start  = tx_start;
        obs_pid    = tx_pid;
        obs_commit = out_commit;
        obs_abort  = out_abort;
        obs_acked  = in_acked;
        obs_sof    = sof_pulse;
    endtask

    task automatic runTransmitter();
        repeat (3) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    task automatic checkResponse(input string tag, input logic s, input logic [3:0] p,
                                 input logic c, input logic ab, input logic ak, input logic sf);
        checkOutput({tag, "/tx_start"}, obs_start, s);
        if (s) checkOutput({tag, "/tx_pid"}, obs_pid, p);
        checkOutput({tag, "/commit"}, obs_commit, c);
        checkOutput({tag, "/abort"}, obs_abort, ab);
        checkOutput({tag, "/in_acked"}, obs_acked, ak);
        checkOutput({tag, "/sof"}, obs_sof, sf);
        if (obs_start) runTransmitter();
    endtask

    task automatic doOut(input logic setup, input logic [6:0] a, input logic [3:0] ep,
                         input logic tv, input logic [3:0] dpid, input int n,
                         input logic dv, input int gap);
        logic hit, stall, want;
        int   sum;
        sum = 0;
        for (int i = 0; i < n; i++) begin
            payload[i] = 8'($urandom);
            sum += int'(payload[i]);
        end
        hit = tv && (a == MY_ADDR) && (int'(ep) < NUM_EP);
        applyStimulus(setup ? PID_SETUP : PID_OUT, {ep, a}, 0, tv);
        checkResponse("out_tok", 0, 4'h0, 0, 0, 0, 0);
        if (hit) begin
            checkOutput("out_cur_ep", cur_ep, ep);
            checkOutput("out_setup_flag", out_setup, setup);
        end
        repeat (gap) @(negedge clk);
        applyStimulus(dpid, 11'h000, n, dv);
        if (!hit) begin
            checkOutput("out_ign_bytes", got_cnt, 0);
            checkResponse("out_ign", 0, 4'h0, 0, 0, 0, 0);
            return;
        end
        checkOutput("out_byte_cnt", got_cnt, n);
        checkOutput("out_byte_sum", got_sum, sum);
        if (!dv || !(dpid == PID_DATA0 || dpid == PID_DATA1)) begin
            checkResponse("out_bad", 0, 4'h0, 0, 1, 0, 0);
            return;
        end
        stall = !setup && ep_stall[ep];
        want  = setup ? 1'b0 : m_out_tog[ep];
        if (stall)                            checkResponse("out_stall", 1, PID_STALL, 0, 1, 0, 0);
        else if (!out_ready)                  checkResponse("out_nak", 1, PID_NAK, 0, 1, 0, 0);
        else if ((dpid == PID_DATA1) != want) checkResponse("out_dup", 1, PID_ACK, 0, 1, 0, 0);
        else begin
            checkResponse("out_ok", 1, PID_ACK, 1, 0, 0, 0);
            if (setup) begin
                m_out_tog[ep] = 1'b1;
                m_in_tog[ep]  = 1'b1;
            end else begin
                m_out_tog[ep] = !m_out_tog[ep];
            end
        end
    endtask

    // host: 0 = ACK, 1 = NAK, 2 = silence until well past the timeout
    task automatic doIn(input logic [6:0] a, input logic [3:0] ep, input logic tv, input int host);
        logic hit;
        int   pulses;
        hit = tv && (a == MY_ADDR) && (int'(ep) < NUM_EP);
        applyStimulus(PID_IN, {ep, a}, 0, tv);
        if (!hit) begin
            checkResponse("in_ign", 0, 4'h0, 0, 0, 0, 0);
            return;
        end
        checkOutput("in_cur_ep", cur_ep, ep);
        if (ep_stall[ep]) begin
            checkResponse("in_stall", 1, PID_STALL, 0, 0, 0, 0);
            return;
        end
        if (!in_ready) begin
            checkResponse("in_nak", 1, PID_NAK, 0, 0, 0, 0);
            return;
        end
        checkResponse("in_data", 1, m_in_tog[ep] ? PID_DATA1 : PID_DATA0, 0, 0, 0, 0);
        if (host == 2) begin
            pulses = 0;
            for (int j = 0; j < TIMEOUT_CYC + 8; j++) begin
                @(negedge clk);
                if (in_acked || tx_start) pulses++;
            end
            checkOutput("in_silent_pulses", pulses, 0);
        end else begin
            applyStimulus((host == 0) ? PID_ACK : PID_NAK, 11'h000, 0, 1'b1);
            checkResponse("in_hs", 0, 4'h0, 0, 0, host == 0, 0);
            if (host == 0) m_in_tog[ep] = !m_in_tog[ep];
        end
    endtask

    task automatic doSof(input logic [10:0] frame, input logic valid);
        applyStimulus(PID_SOF, frame, 0, valid);
        checkResponse("sof", 0, 4'h0, 0, 0, 0, valid);
        if (valid) m_frame = frame;
        checkOutput("sof_frame", frame_num, m_frame);
    endtask

    task automatic resetModel();
        for (int e = 0; e < NUM_EP; e++) begin
            m_out_tog[e] = 1'b0;
            m_in_tog[e]  = 1'b0;
        end
        m_frame = 11'h000;
    endtask

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: time limit reached before completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int hits, at_cyc, r;
        logic [3:0] ep, dpid;
        logic [6:0] a;
        logic       tv;

        rst_n = 1'b0; dev_addr = MY_ADDR; ep_stall = '0;
        rx_packet_pid = 4'h0; rx_packet_addr = 11'h000; rx_packet_byte = 8'h00;
        rx_packet_byte_en = 1'b0; rx_packet_valid = 1'b0; rx_packet_fin = 1'b0;
        tx_done = 1'b0; out_ready = 1'b1; in_ready = 1'b1;
        resetModel();
        repeat (3) @(negedge clk);
        checkOutput("rst_tx_start", tx_start, 0);
        checkOutput("rst_tx_pid", tx_pid, 0);
        checkOutput("rst_cur_ep", cur_ep, 0);
        checkOutput("rst_frame", frame_num, 0);
        checkOutput("rst_verdicts", {out_commit, out_abort, in_acked, sof_pulse, out_byte_en, out_setup}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("[TB] OUT toggle sequence on ep1");
        doOut(0, MY_ADDR, 4'd1, 1, PID_DATA0, 3, 1, 2);
        doOut(0, MY_ADDR, 4'd1, 1, PID_DATA0, 3, 1, 0);

        $display("[TB] SETUP on ep0 followed by IN");
        doOut(1, MY_ADDR, 4'd0, 1, PID_DATA0, 8, 1, 1);
        doIn(MY_ADDR, 4'd0, 1, 0);

        $display("[TB] IN retry after timeout on ep2");
        doIn(MY_ADDR, 4'd2, 1, 2);
        doIn(MY_ADDR, 4'd2, 1, 0);
        doIn(MY_ADDR, 4'd2, 1, 1);

        $display("[TB] NAK and STALL handling");
        out_ready = 1'b0;
        doOut(0, MY_ADDR, 4'd0, 1, PID_DATA1, 4, 1, 1);
        out_ready = 1'b1;
        ep_stall  = 4'b0001;
        doIn(MY_ADDR, 4'd0, 1, 0);
        doOut(0, MY_ADDR, 4'd0, 1, PID_DATA0, 2, 1, 0);
        ep_stall  = '0;

        $display("[TB] address filtering and SOF");
        doIn(7'h05, 4'd1, 1, 0);
        doOut(0, 7'h05, 4'd1, 1, PID_DATA0, 2, 1, 0);
        doIn(MY_ADDR, 4'd5, 1, 0);
        doSof(11'h3A5, 1);

        $display("[TB] OUT data timeout and mid-packet freeze");
        applyStimulus(PID_OUT, {4'd3, MY_ADDR}, 0, 1'b1);
        checkResponse("to_tok", 0, 4'h0, 0, 0, 0, 0);
        hits = 0; at_cyc = -1;
        for (int j = 1; j <= TIMEOUT_CYC + 8; j++) begin
            @(negedge clk);
            if (out_abort) begin
                hits++;
                at_cyc = j;
            end
        end
        checkOutput("to_abort_count", hits, 1);
        checkOutput("to_abort_cycle", at_cyc, TIMEOUT_CYC);
        doOut(0, MY_ADDR, 4'd1, 1, m_out_tog[1] ? PID_DATA1 : PID_DATA0, 10, 1, TIMEOUT_CYC - 11);

        $display("[TB] randomized transactions");
        for (int t = 0; t < 80; t++) begin
            ep_stall  = ($urandom_range(0, 3) == 0) ? NUM_EP'($urandom) : '0;
            out_ready = ($urandom_range(0, 4) != 0);
            in_ready  = ($urandom_range(0, 4) != 0);
            ep        = 4'($urandom_range(0, 5));
            a         = ($urandom_range(0, 7) == 0) ? 7'h05 : MY_ADDR;
            tv        = ($urandom_range(0, 9) != 0);
            r         = int'($urandom_range(0, 9));
            dpid      = (r == 9) ? PID_ACK : ((r % 2 == 1) ? PID_DATA1 : PID_DATA0);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: doOut(0, a, ep, tv, dpid, (r == 9) ? 0 : int'($urandom_range(0, 8)),
                                  $urandom_range(0, 7) != 0, int'($urandom_range(0, 4)));
                4:          doOut(1, a, ep, tv, dpid, (r == 9) ? 0 : 8,
                                  $urandom_range(0, 7) != 0, int'($urandom_range(0, 4)));
                5, 6, 7:    doIn(a, ep, tv, ($urandom_range(0, 3) == 0) ? 1 : 0);
                8:          doSof(11'($urandom), tv);
                default:    repeat ($urandom_range(1, 6)) @(negedge clk);
            endcase
        end

        $display("[TB] reset while waiting for IN handshake");
        ep_stall = '0; in_ready = 1'b1; out_ready = 1'b1;
        applyStimulus(PID_IN, {4'd2, MY_ADDR}, 0, 1'b1);
        checkResponse("rst_in", 1, m_in_tog[2] ? PID_DATA1 : PID_DATA0, 0, 0, 0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_acked", in_acked, 0);
        checkOutput("rst_mid_cur_ep", cur_ep, 0);
        checkOutput("rst_mid_tx_pid", tx_pid, 0);
        checkOutput("rst_mid_frame", frame_num, 0);
        rst_n = 1'b1;
        resetModel();
        @(negedge clk);
        applyStimulus(PID_ACK, 11'h000, 0, 1'b1);
        checkResponse("rst_late_ack", 0, 4'h0, 0, 0, 0, 0);
        doIn(MY_ADDR, 4'd2, 1, 0);
        doOut(0, MY_ADDR, 4'd1, 1, PID_DATA0, 2, 1, 0);

        repeat (4) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
